// File: rtl/pending_priority_encoder.sv
// Registered N-input priority encoder: request pulses are captured into a pending
// register and handed out one index at a time over a valid/ready output stage.
module pending_priority_encoder #(
    parameter int N       = 8,
    parameter int W       = $clog2(N),
    parameter bit RR_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         clr_all,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   pending_reg, pending_next;
    logic [W-1:0]   idx_reg, idx_next;
    logic [W-1:0]   last_idx_reg, last_idx_next;
    logic           overflow_reg, overflow_next;
    logic [N-1:0]   load_mask;
    logic [W-1:0]   base_idx;
    logic [W-1:0]   sel;
    logic           load;
    logic [W-1:0]   cand [N];

    // Fixed priority is the round-robin order seen from last_idx = 0.
    assign base_idx = RR_MODE ? last_idx_reg : '0;

    // cand[k] is the (k+1)-th line to inspect: base-1, base-2, ... wrapping modulo N.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = W'((int'(base_idx) + 2 * N - gi - 1) % N);
    end

    always_comb begin
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_reg[cand[k]]) begin
                sel = cand[k];
            end
        end
    end

    assign out_valid = (state_reg == HOLD);
    assign load      = (!out_valid || out_ready) && (|pending_reg);
    assign load_mask = load ? (N'(1) << sel) : '0;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        last_idx_next = last_idx_reg;
        case (state_reg)
            IDLE: if (load) state_next = HOLD;
            HOLD: if (out_ready && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (load) begin
            idx_next = sel;
            if (RR_MODE) last_idx_next = sel;
        end
    end

    // Fresh requests win over both clr_all and the load clear on the same bit.
    assign pending_next  = (pending_reg & ~load_mask & ~{N{clr_all}}) | req_in;
    assign overflow_next = (|(req_in & pending_reg & ~load_mask)) && !clr_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            idx_reg      <= '0;
            last_idx_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            idx_reg      <= idx_next;
            last_idx_reg <= last_idx_next;
            overflow_reg <= overflow_next;
        end
    end

    assign out_idx  = idx_reg;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder: a fixed-priority and a round-robin instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_pending_priority_encoder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         clr = 1'b0;
    logic         rdy = 1'b0;

    logic         vf, vr, of, orr;
    logic [2:0]   idxf, idxr;
    logic [N-1:0] pf, pr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pending_priority_encoder #(.N(N), .RR_MODE(1'b0)) dut_f (
        .clk(clk), .rst(rst), .req_in(req), .clr_all(clr), .out_ready(rdy),
        .out_valid(vf), .out_idx(idxf), .pending(pf), .overflow(of)
    );

    pending_priority_encoder #(.N(N), .RR_MODE(1'b1)) dut_r (
        .clk(clk), .rst(rst), .req_in(req), .clr_all(clr), .out_ready(rdy),
        .out_valid(vr), .out_idx(idxr), .pending(pr), .overflow(orr)
    );

    // Model state per instance: 0 = fixed priority, 1 = round-robin.
    logic [N-1:0] mp [2];
    logic         mv [2];
    int           mi [2];
    int           ml [2];
    logic         mo [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mp[m] = '0; mv[m] = 1'b0; mi[m] = 0; ml[m] = 0; mo[m] = 1'b0;
        end
    endtask

    task automatic model_step(int m);
        logic [N-1:0] p;
        logic [N-1:0] lm;
        int sel;
        int c;
        p   = mp[m];
        lm  = '0;
        sel = -1;
        if (p != 0 && (!mv[m] || rdy)) begin
            for (int k = 1; k <= N; k++) begin
                c = (ml[m] - k + N) % N;
                if (sel < 0 && p[c]) sel = c;
            end
            lm[sel] = 1'b1;
        end
        mo[m] = ((req & p & ~lm) != 0) && !clr;
        mp[m] = (clr ? '0 : (p & ~lm)) | req;
        if (sel >= 0) begin
            mv[m] = 1'b1;
            mi[m] = sel;
            if (m == 1) ml[m] = sel;
        end else if (mv[m] && rdy) begin
            mv[m] = 1'b0;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("f_valid", int'(vf), int'(mv[0]));
            chk("f_idx", int'(idxf), mi[0]);
            chk("f_pending", int'(pf), int'(mp[0]));
            chk("f_overflow", int'(of), int'(mo[0]));
            chk("r_valid", int'(vr), int'(mv[1]));
            chk("r_idx", int'(idxr), mi[1]);
            chk("r_pending", int'(pr), int'(mp[1]));
            chk("r_overflow", int'(orr), int'(mo[1]));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && vf && rdy) $display("xfer fixed idx=%0d t=%0t", idxf, $time);
            if (!rst && vr && rdy) $display("xfer rr    idx=%0d t=%0t", idxr, $time);
        end
    end

    task automatic cyc(logic [N-1:0] r, logic c, logic rd);
        req = r; clr = c; rdy = rd;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] rr;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_valid", int'(vf), 0);
        chk("reset_idx", int'(idxf), 0);
        chk("reset_pending", int'(pf), 0);
        chk("reset_overflow", int'(of), 0);

        // Three-way burst drained with out_ready held high.
        cyc(8'h29, 1'b0, 1'b1);
        chk("t1_pending", int'(pf), 8'h29);
        chk("t1_valid0", int'(vf), 0);
        cyc(8'h00, 1'b0, 1'b1); chk("t1_idx5", int'(idxf), 5); chk("t1_v5", int'(vf), 1);
        cyc(8'h00, 1'b0, 1'b1); chk("t1_idx3", int'(idxf), 3);
        cyc(8'h00, 1'b0, 1'b1); chk("t1_idx0", int'(idxf), 0); chk("t1_v0", int'(vf), 1);
        cyc(8'h00, 1'b0, 1'b1); chk("t1_idle", int'(vf), 0);

        // Backpressure holds the offered index stable.
        cyc(8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(8'h00, 1'b0, 1'b0);
            chk("t2_hold_idx", int'(idxf), 6);
            chk("t2_hold_pend", int'(pf), 8'h04);
        end
        cyc(8'h00, 1'b0, 1'b1); chk("t2_idx2", int'(idxf), 2); chk("t2_pend0", int'(pf), 0);
        cyc(8'h00, 1'b0, 1'b1); chk("t2_idle", int'(vf), 0);

        // Re-request of a pending line pulses overflow once, grants once.
        cyc(8'h01, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0); chk("t3_hold0", int'(idxf), 0);
        cyc(8'h10, 1'b0, 1'b0); chk("t3_ov_a", int'(of), 0);
        cyc(8'h10, 1'b0, 1'b0); chk("t3_ov_b", int'(of), 1);
        cyc(8'h00, 1'b0, 1'b0); chk("t3_ov_c", int'(of), 0);
        cyc(8'h00, 1'b0, 1'b1); chk("t3_idx4", int'(idxf), 4);
        cyc(8'h00, 1'b0, 1'b1); chk("t3_idle", int'(vf), 0);

        // clr_all against a simultaneous request, offered index untouched.
        cyc(8'h80, 1'b0, 1'b0);
        cyc(8'h0F, 1'b0, 1'b0); chk("t5_pend_pre", int'(pf), 8'h0F);
        cyc(8'h04, 1'b1, 1'b0);
        chk("t5_pend", int'(pf), 8'h04);
        chk("t5_idx", int'(idxf), 7);
        chk("t5_valid", int'(vf), 1);
        cyc(8'h00, 1'b0, 1'b1); chk("t5_idx2", int'(idxf), 2);
        cyc(8'h00, 1'b0, 1'b1); chk("t5_idle", int'(vf), 0);

        // Randomised traffic, checked by the per-cycle compare.
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cyc(rr, $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
        end
        cyc(8'h00, 1'b0, 1'b1);

        // Asynchronous reset in the middle of HOLD.
        cyc(8'hA5, 1'b0, 1'b0);
        cyc(8'hA5, 1'b0, 1'b0);
        chk("t6_pend", int'(pr), 8'hA5);
        chk("t6_valid", int'(vr), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_r_valid", int'(vr), 0);
        chk("t6_r_idx", int'(idxr), 0);
        chk("t6_r_pend", int'(pr), 0);
        chk("t6_f_valid", int'(vf), 0);
        chk("t6_f_pend", int'(pf), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Round-robin rotation under continuous requests.
        cyc(8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(8'hFF, 1'b0, 1'b1);
            chk("t4_rr_idx", int'(idxr), (7 - i + 16) % 8);
            chk("t4_fixed_idx", int'(idxf), 7);
        end
        cyc(8'h00, 1'b0, 1'b1);
        repeat (10) cyc(8'h00, 1'b0, 1'b1);
        chk("final_idle", int'(vr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
